// File: rtl/soc_pkg.sv
// Shared definitions for simple_mem_arbiter: response codes, the FSM state
// encoding, and a helper for the width of a requester index.
package soc_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    SMA_IDLE = 1'b0,
    SMA_RESP = 1'b1
  } sma_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int sma_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simple_mem_rr_pick.sv
// Combinational requester picker. With RR = 1 the search starts at ptr_i
// and wraps modulo NUM_REQ. With RR = 0 it starts at 0, which gives fixed
// priority to the lowest index.
module simple_mem_rr_pick
  import soc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter bit RR      = 1'b1
) (
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [sma_idx_w(NUM_REQ)-1:0]  ptr_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [sma_idx_w(NUM_REQ)-1:0]  idx_o,
  output logic                           any_o
);

  localparam int OW = sma_idx_w(NUM_REQ);

  // Find the first asserted request at or after the start index.
  always_comb begin
    int start;
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    start = RR ? int'(ptr_i) : 0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = start + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = OW'(j);
      end
    end
  end

endmodule

// File: rtl/simple_mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one single-cycle memory port, registers
// the memory response, and returns it to the winner over valid/ready.
// Optional feature: define SIMPLE_MEM_ARBITER_RR_EN for round-robin
// arbitration; otherwise the lowest valid index wins.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// req_ready_o depends combinationally on req_valid_i, so requesters must not
// derive valid from ready; they hold valid and payload until ready. The
// response (rsp_valid_o, rsp_rdata_o, rsp_resp_o) is held until rsp_ready_i
// of the owner is seen, and a new grant may be issued in that same cycle.
module simple_mem_arbiter
  import soc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic [1:0]                  rsp_resp_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_waddr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [DATA_W/8-1:0]         mem_wstrb_o,
  input  logic [1:0]                  mem_wresp_i,
  output logic                        mem_re_o,
  output logic [ADDR_W-1:0]           mem_raddr_o,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  input  logic [1:0]                  mem_rresp_i,
  output logic                        dbg_state_o
);

  localparam int OW = sma_idx_w(NUM_REQ);
  localparam int SW = DATA_W / 8;

  sma_state_e          state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [OW-1:0]       rr_ptr;

  logic [NUM_REQ-1:0]  gnt;
  logic [OW-1:0]       g_idx;
  logic                g_any;
  logic                grant_en;
  logic                grant;

`ifdef SIMPLE_MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pointer: the next search starts just after the last winner.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  // Advance the pointer on every grant, wrapping from NUM_REQ-1 to 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (g_idx == OW'(NUM_REQ - 1)) ? '0 : g_idx + OW'(1);
  end

  assign rr_ptr = rr_ptr_q;
`else
  localparam bit RR = 1'b0;
  assign rr_ptr = '0;
`endif

  simple_mem_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .RR      (RR)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr),
    .gnt_o (gnt),
    .idx_o (g_idx),
    .any_o (g_any)
  );

  // A grant needs a free response slot: idle, or the pending one retiring now.
  // Reset masks it so nothing leaks out combinationally while held.
  assign grant_en = !arst_i && ((state_q == SMA_IDLE) || rsp_ready_i[owner_q]);
  assign grant    = grant_en && g_any;

  assign dbg_state_o = state_q;

  // State, owner and registered memory response.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= SMA_IDLE;
      owner_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // Next state, memory port drive and response outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = rdata_q;
    rsp_resp_o  = resp_q;
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    mem_re_o    = 1'b0;
    mem_raddr_o = '0;

    if (state_q == SMA_RESP) begin
      rsp_valid_o[owner_q] = 1'b1;
      if (rsp_ready_i[owner_q]) state_d = SMA_IDLE;
    end

    if (grant) begin
      req_ready_o = gnt;
      owner_d     = g_idx;
      state_d     = SMA_RESP;
      if (req_write_i[g_idx]) begin
        mem_we_o    = 1'b1;
        mem_waddr_o = req_addr_i[g_idx*ADDR_W +: ADDR_W];
        mem_wdata_o = req_wdata_i[g_idx*DATA_W +: DATA_W];
        mem_wstrb_o = req_wstrb_i[g_idx*SW +: SW];
        resp_d      = mem_wresp_i;
        rdata_d     = '0;
      end else begin
        mem_re_o    = 1'b1;
        mem_raddr_o = req_addr_i[g_idx*ADDR_W +: ADDR_W];
        resp_d      = mem_rresp_i;
        rdata_d     = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Testbench for simple_mem_arbiter (NUM_REQ=4, ADDR_W=32, DATA_W=64).
// Expected responses are queued when a request is issued; a monitor pops and
// compares them on every response handshake.
module tb_simple_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

`ifdef SIMPLE_MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic [SW-1:0]   mem_wstrb;
  logic [1:0]      mem_wresp = 2'b00;
  logic            mem_re;
  logic [AW-1:0]   mem_raddr;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      mem_rresp = 2'b00;
  logic            dbg_state;

  logic            addr_mode = 1'b0;
  logic [DW-1:0]   rdata_fixed = '0;

  // Memory model: either a fixed word or a word derived from the address.
  assign mem_rdata = addr_mode ? {32'hCAFE_0000, mem_raddr} : rdata_fixed;

  // {idx[1:0], resp[1:0], rdata[63:0]}
  logic [67:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  simple_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .mem_we_o    (mem_we),
    .mem_waddr_o (mem_waddr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .mem_wresp_i (mem_wresp),
    .mem_re_o    (mem_re),
    .mem_raddr_o (mem_raddr),
    .mem_rdata_i (mem_rdata),
    .mem_rresp_i (mem_rresp),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit w, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic push(input int idx, input logic [1:0] resp, input logic [63:0] rdata);
    logic [1:0] i2;
    i2 = idx[1:0];
    exp_q.push_back({i2, resp, rdata});
  endtask

  task automatic do_reset();
    arst = 1'b1;
    step();
    arst = 1'b0;
  endtask

  // Monitor: every response handshake must match the head of the queue.
  initial begin
    logic [67:0] e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!arst && |(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {60'h0, rsp_valid}, 64'h0);
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e[67:66]] = 1'b1;
          check("rsp_valid", {60'h0, rsp_valid}, {60'h0, oh});
          check("rsp_resp", {62'h0, rsp_resp}, {62'h0, e[65:64]});
          check("rsp_rdata", rsp_rdata, e[63:0]);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int first, second, third;
    logic [DW-1:0] held;

    // Reset state, with a request asserted to prove outputs are masked.
    req_valid = 4'b0100;
    set_req(2, 1'b0, 32'h100, '0, '0);
    samp();
    check("rst_req_ready", {60'h0, req_ready}, 64'h0);
    check("rst_rsp_valid", {60'h0, rsp_valid}, 64'h0);
    check("rst_mem_re", {63'h0, mem_re}, 64'h0);
    check("rst_mem_raddr", {32'h0, mem_raddr}, 64'h0);
    check("rst_rdata", rsp_rdata, 64'h0);
    check("rst_state", {63'h0, dbg_state}, 64'h0);
    req_valid = '0;
    step();
    arst = 1'b0;

    // Single read by requester 2.
    step();
    rdata_fixed = 64'h0000_0000_DEAD_BEEF;
    mem_rresp   = 2'b00;
    req_valid   = 4'b0100;
    samp();
    check("rd_mem_re", {63'h0, mem_re}, 64'h1);
    check("rd_mem_we", {63'h0, mem_we}, 64'h0);
    check("rd_raddr", {32'h0, mem_raddr}, 64'h100);
    check("rd_req_ready", {60'h0, req_ready}, 64'b0100);
    push(2, 2'b00, 64'h0000_0000_DEAD_BEEF);
    step();
    req_valid = '0;
    samp();
    check("rd_rsp_valid", {60'h0, rsp_valid}, 64'b0100);
    check("rd_mem_re_pulse", {63'h0, mem_re}, 64'h0);
    step();
    rsp_ready = 4'b1111;
    samp();
    step();
    samp();
    check("rd_idle", {60'h0, rsp_valid}, 64'h0);

    // Write with slave error by requester 0.
    step();
    set_req(0, 1'b1, 32'h40, 64'h55, 8'h01);
    mem_wresp = 2'b10;
    req_valid = 4'b0001;
    samp();
    check("wr_mem_we", {63'h0, mem_we}, 64'h1);
    check("wr_mem_re", {63'h0, mem_re}, 64'h0);
    check("wr_waddr", {32'h0, mem_waddr}, 64'h40);
    check("wr_wdata", mem_wdata, 64'h55);
    check("wr_wstrb", {56'h0, mem_wstrb}, 64'h01);
    push(0, 2'b10, 64'h0);
    step();
    req_valid = '0;
    mem_wresp = 2'b00;
    samp();
    check("wr_strobe_idle", {56'h0, mem_wstrb}, 64'h0);
    step();

    // Contention from a fresh reset: all four read, one grant per cycle.
    do_reset();
    addr_mode = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h200 + 32'(i * 8), '0, '0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      samp();
      first = RR ? (k % N) : 0;
      check("cont_req_ready", {60'h0, req_ready}, 64'h1 << first);
      check("cont_raddr", {32'h0, mem_raddr}, 64'h200 + 64'(first * 8));
      push(first, 2'b00, {32'hCAFE_0000, 32'h200 + 32'(first * 8)});
      step();
    end
    req_valid = '0;
    samp();
    step();

    // Backpressure: response from requester 1 stalls a write from requester 3.
    addr_mode   = 1'b0;
    rdata_fixed = 64'h1234_5678_9ABC_DEF0;
    rsp_ready   = '0;
    set_req(1, 1'b0, 32'h300, '0, '0);
    set_req(3, 1'b1, 32'h400, 64'hAA, 8'hFF);
    req_valid = 4'b0010;
    samp();
    check("bp_grant", {60'h0, req_ready}, 64'b0010);
    push(1, 2'b00, 64'h1234_5678_9ABC_DEF0);
    step();
    req_valid   = 4'b1000;
    rdata_fixed = 64'hFFFF_0000_FFFF_0000;
    held        = 64'h1234_5678_9ABC_DEF0;
    for (int k = 0; k < 5; k++) begin
      samp();
      check("bp_rsp_valid", {60'h0, rsp_valid}, 64'b0010);
      check("bp_rsp_rdata", rsp_rdata, held);
      check("bp_no_access", {62'h0, mem_we, mem_re}, 64'h0);
      check("bp_no_ready", {60'h0, req_ready}, 64'h0);
      step();
    end
    rsp_ready = 4'b1111;
    samp();
    check("bp_b2b_grant", {60'h0, req_ready}, 64'b1000);
    check("bp_b2b_we", {63'h0, mem_we}, 64'h1);
    push(3, 2'b00, 64'h0);
    step();
    req_valid = '0;
    samp();
    step();

    // Wrap: move the pointer to 3, then requesters 1 and 3 contend.
    addr_mode = 1'b1;
    set_req(2, 1'b0, 32'h500, '0, '0);
    set_req(1, 1'b0, 32'h510, '0, '0);
    set_req(3, 1'b0, 32'h530, '0, '0);
    set_req(0, 1'b0, 32'h5F0, '0, '0);
    req_valid = 4'b0100;
    samp();
    check("wrap_setup", {60'h0, req_ready}, 64'b0100);
    push(2, 2'b00, {32'hCAFE_0000, 32'h500});
    step();
    req_valid = 4'b1010;
    first  = RR ? 3 : 1;
    second = RR ? 1 : 3;
    samp();
    check("wrap_first", {60'h0, req_ready}, 64'h1 << first);
    push(first, 2'b00, {32'hCAFE_0000, (first == 3) ? 32'h530 : 32'h510});
    step();
    req_valid[first] = 1'b0;
    samp();
    check("wrap_second", {60'h0, req_ready}, 64'h1 << second);
    push(second, 2'b00, {32'hCAFE_0000, (second == 3) ? 32'h530 : 32'h510});
    step();
    // Pointer is 2 after granting 1 (RR), so 3 wins over 0 and 1.
    req_valid = 4'b1011;
    third = (RR && second == 1) ? 3 : 0;
    samp();
    check("wrap_ptr", {60'h0, req_ready}, 64'h1 << third);
    push(third, 2'b00, {32'hCAFE_0000, (third == 3) ? 32'h530 : 32'h5F0});
    step();
    req_valid = '0;
    samp();
    step();

    // Reset mid-response: the pending response is dropped.
    rsp_ready = '0;
    set_req(1, 1'b0, 32'h600, '0, '0);
    req_valid = 4'b0010;
    samp();
    check("mr_grant", {60'h0, req_ready}, 64'b0010);
    step();
    req_valid = '0;
    samp();
    check("mr_rsp_valid", {60'h0, rsp_valid}, 64'b0010);
    set_req(0, 1'b0, 32'h700, '0, '0);
    set_req(2, 1'b0, 32'h720, '0, '0);
    req_valid = 4'b0101;
    #1;
    arst = 1'b1;
    #1;
    check("mr_async_rsp_valid", {60'h0, rsp_valid}, 64'h0);
    check("mr_async_req_ready", {60'h0, req_ready}, 64'h0);
    check("mr_async_mem_re", {63'h0, mem_re}, 64'h0);
    check("mr_async_rdata", rsp_rdata, 64'h0);
    check("mr_async_state", {63'h0, dbg_state}, 64'h0);
    step();
    arst = 1'b0;
    rsp_ready = 4'b1111;
    samp();
    check("mr_after_grant", {60'h0, req_ready}, 64'b0001);
    push(0, 2'b00, {32'hCAFE_0000, 32'h700});
    step();
    req_valid = 4'b0100;
    samp();
    check("mr_next_grant", {60'h0, req_ready}, 64'b0100);
    push(2, 2'b00, {32'hCAFE_0000, 32'h720});
    step();
    req_valid = '0;
    samp();
    step();
    samp();

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
